// File: rtl/instr_mem_sdp.sv
// Simple-dual-port instruction memory with a sequential load engine.
// The loader streams words in through a valid/ready handshake starting at address 0.
// The fetch side reads at any time with a latency of 1 or 2 cycles and is told
// when it reads past the last loaded word.
module instr_mem_sdp #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_start,
  input  logic              i_load_end,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_rd_oob,
  output logic [ADDR_W:0]   o_word_cnt,
  output logic [ADDR_W-1:0] o_max_addr,
  output logic              o_loaded
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_CNT = FULL_CNT - 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_READY
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                wr_fire;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                rd_oob;
  logic [DATA_W-1:0]   rd_word;

  logic                s1_valid, s1_oob;
  logic [DATA_W-1:0]   s1_data;

  // A load restart wins over everything else in the same cycle, so no word is
  // accepted while i_load_start is high.
  assign o_wr_ready = (state_q == ST_LOAD) && (cnt_q < FULL_CNT);
  assign wr_fire    = i_wr_valid && o_wr_ready && !i_load_start;

  // Load FSM registers: state, loaded word count and the next write address.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_EMPTY;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Next-state logic: restart, accept words, and leave LOAD on request or when full.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    if (i_load_start) begin
      state_d  = ST_LOAD;
      cnt_d    = '0;
      wr_ptr_d = '0;
    end else if (state_q == ST_LOAD) begin
      if (wr_fire) begin
        cnt_d    = cnt_q + 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (wr_fire && (cnt_q == LAST_CNT)) begin
        state_d = ST_READY;
      end else if (i_load_end) begin
        state_d = ST_READY;
      end
    end
  end

  // Storage array; intentionally not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q] <= i_wr_data;
    end
  end

  // Read-side lookup: range check against the count before this cycle's write,
  // with optional forwarding of a same-address write for in-range rewrites.
  always_comb begin
    rd_oob  = i_rd_en && ({1'b0, i_rd_addr} >= cnt_q);
    rd_word = mem[i_rd_addr];
    if ((RDW_MODE != 0) && wr_fire && (i_rd_addr == wr_ptr_q)) begin
      rd_word = i_wr_data;
    end
  end

  // First read stage; data holds its last value when no read is issued.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= i_rd_en;
      s1_oob   <= rd_oob;
      if (i_rd_en) begin
        s1_data <= rd_oob ? '0 : rd_word;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic              s2_valid, s2_oob;
      logic [DATA_W-1:0] s2_data;

      // Optional second read stage; reset flushes anything still in flight.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          s2_valid <= 1'b0;
          s2_oob   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_oob   <= s1_oob;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign o_rd_valid = s2_valid;
      assign o_rd_oob   = s2_oob;
      assign o_rd_data  = s2_data;
    end else begin : g_lat1
      assign o_rd_valid = s1_valid;
      assign o_rd_oob   = s1_oob;
      assign o_rd_data  = s1_data;
    end
  endgenerate

  assign o_word_cnt = cnt_q;
  assign o_max_addr = (cnt_q == '0) ? '0 : ADDR_W'(cnt_q - 1'b1);
  assign o_loaded   = (state_q == ST_READY);

endmodule

// File: tb/tb_instr_mem_sdp.sv
// Bench for instr_mem_sdp: a latency-1 old-data instance and a latency-2 bypass
// instance share all inputs and are compared every cycle against a behavioural model.
module tb_instr_mem_sdp;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n, load_start, load_end, wr_valid, rd_en;
  logic [15:0] wr_data;
  logic [7:0]  rd_addr;

  logic        a_wr_ready, a_rd_valid, a_rd_oob, a_loaded;
  logic [15:0] a_rd_data;
  logic [8:0]  a_word_cnt;
  logic [7:0]  a_max_addr;
  logic        b_wr_ready, b_rd_valid, b_rd_oob, b_loaded;
  logic [15:0] b_rd_data;
  logic [8:0]  b_word_cnt;
  logic [7:0]  b_max_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_mem_sdp #(.DATA_W(16), .ADDR_W(8), .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start), .i_load_end(load_end),
    .i_wr_valid(wr_valid), .o_wr_ready(a_wr_ready), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(a_rd_data),
    .o_rd_valid(a_rd_valid), .o_rd_oob(a_rd_oob), .o_word_cnt(a_word_cnt),
    .o_max_addr(a_max_addr), .o_loaded(a_loaded)
  );

  instr_mem_sdp #(.DATA_W(16), .ADDR_W(8), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start), .i_load_end(load_end),
    .i_wr_valid(wr_valid), .o_wr_ready(b_wr_ready), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(b_rd_data),
    .o_rd_valid(b_rd_valid), .o_rd_oob(b_rd_oob), .o_word_cnt(b_word_cnt),
    .o_max_addr(b_max_addr), .o_loaded(b_loaded)
  );

  // Behavioural reference model
  typedef enum {M_EMPTY, M_LOAD, M_READY} mstate_t;
  mstate_t     m_state;
  int          m_cnt, m_wp;
  logic [15:0] m_mem [DEPTH];
  logic        e1_valid, e1_oob, e2_valid, e2_oob, h_valid, h_oob;
  logic [15:0] e1_data, e2_data, h_data;

  typedef struct {
    logic ls, le, wv; logic [15:0] wd; logic re; logic [7:0] ra;
    int e_cnt; logic e_ready, e_loaded; int e_max;
    logic e_valid; logic [15:0] e_data; logic e_oob;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: predict from the model, clock the DUTs, then compare everything.
  task automatic step();
    logic acc, rv, roob;
    logic [15:0] d_old, d_new;
    if (!rst_n) begin
      m_state = M_EMPTY; m_cnt = 0; m_wp = 0;
      e1_valid = 0; e1_oob = 0; e1_data = 0;
      e2_valid = 0; e2_oob = 0; e2_data = 0;
      h_valid = 0; h_oob = 0; h_data = 0;
    end else begin
      acc   = (m_state == M_LOAD) && (m_cnt < DEPTH) && wr_valid && !load_start;
      rv    = rd_en;
      roob  = rd_en && (int'(rd_addr) >= m_cnt);
      d_old = roob ? 16'h0 : m_mem[rd_addr];
      d_new = (acc && !roob && int'(rd_addr) == m_wp) ? wr_data : d_old;
      e2_valid = h_valid; e2_oob = h_oob;
      if (h_valid) e2_data = h_data;
      h_valid = rv; h_oob = roob;
      if (rv) h_data = d_new;
      e1_valid = rv; e1_oob = roob;
      if (rv) e1_data = d_old;
      if (acc) begin
        m_mem[m_wp] = wr_data;
        m_wp = (m_wp + 1) % DEPTH;
        m_cnt++;
      end
      if (load_start) begin
        m_state = M_LOAD; m_cnt = 0; m_wp = 0;
      end else if (m_state == M_LOAD && (m_cnt == DEPTH || load_end)) begin
        m_state = M_READY;
      end
    end
    @(posedge clk);
    #1;
    check("a_valid", 32'(a_rd_valid), 32'(e1_valid));
    check("a_oob", 32'(a_rd_oob), 32'(e1_oob));
    check("a_data", 32'(a_rd_data), 32'(e1_data));
    check("b_valid", 32'(b_rd_valid), 32'(e2_valid));
    check("b_oob", 32'(b_rd_oob), 32'(e2_oob));
    check("b_data", 32'(b_rd_data), 32'(e2_data));
    check("a_cnt", 32'(a_word_cnt), 32'(m_cnt));
    check("b_cnt", 32'(b_word_cnt), 32'(m_cnt));
    check("a_max", 32'(a_max_addr), 32'((m_cnt == 0) ? 0 : m_cnt - 1));
    check("b_max", 32'(b_max_addr), 32'((m_cnt == 0) ? 0 : m_cnt - 1));
    check("a_loaded", 32'(a_loaded), 32'(m_state == M_READY));
    check("b_loaded", 32'(b_loaded), 32'(m_state == M_READY));
    check("a_ready", 32'(a_wr_ready), 32'(m_state == M_LOAD && m_cnt < DEPTH));
    check("b_ready", 32'(b_wr_ready), 32'(m_state == M_LOAD && m_cnt < DEPTH));
  endtask

  task automatic applyStimulus(input logic ls, input logic le, input logic wv,
                               input logic [15:0] wd, input logic re, input logic [7:0] ra);
    load_start = ls; load_end = le; wr_valid = wv; wr_data = wd; rd_en = re; rd_addr = ra;
    step();
  endtask

  task automatic checkOutput(input int i);
    check($sformatf("vec%0d_cnt", i), 32'(a_word_cnt), 32'(vecs[i].e_cnt));
    check($sformatf("vec%0d_ready", i), 32'(a_wr_ready), 32'(vecs[i].e_ready));
    check($sformatf("vec%0d_loaded", i), 32'(a_loaded), 32'(vecs[i].e_loaded));
    check($sformatf("vec%0d_max", i), 32'(a_max_addr), 32'(vecs[i].e_max));
    check($sformatf("vec%0d_valid", i), 32'(a_rd_valid), 32'(vecs[i].e_valid));
    check($sformatf("vec%0d_data", i), 32'(a_rd_data), 32'(vecs[i].e_data));
    check($sformatf("vec%0d_oob", i), 32'(a_rd_oob), 32'(vecs[i].e_oob));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0;
    // ls le wv wd re ra | cnt ready loaded max valid data oob
    vecs[0]  = '{1, 0, 0, 16'h0000, 0, 8'd0, 0, 1, 0, 0, 0, 16'h0000, 0};
    vecs[1]  = '{0, 0, 1, 16'h00A1, 0, 8'd0, 1, 1, 0, 0, 0, 16'h0000, 0};
    vecs[2]  = '{0, 0, 1, 16'h00B2, 0, 8'd0, 2, 1, 0, 1, 0, 16'h0000, 0};
    vecs[3]  = '{0, 0, 1, 16'h00C3, 0, 8'd0, 3, 1, 0, 2, 0, 16'h0000, 0};
    vecs[4]  = '{0, 1, 0, 16'h0000, 0, 8'd0, 3, 0, 1, 2, 0, 16'h0000, 0};
    vecs[5]  = '{0, 0, 0, 16'h0000, 1, 8'd1, 3, 0, 1, 2, 1, 16'h00B2, 0};
    vecs[6]  = '{0, 0, 0, 16'h0000, 1, 8'd0, 3, 0, 1, 2, 1, 16'h00A1, 0};
    vecs[7]  = '{0, 0, 0, 16'h0000, 1, 8'd1, 3, 0, 1, 2, 1, 16'h00B2, 0};
    vecs[8]  = '{0, 0, 0, 16'h0000, 1, 8'd2, 3, 0, 1, 2, 1, 16'h00C3, 0};
    vecs[9]  = '{0, 0, 0, 16'h0000, 1, 8'd3, 3, 0, 1, 2, 1, 16'h0000, 1};
    vecs[10] = '{0, 0, 0, 16'h0000, 0, 8'd0, 3, 0, 1, 2, 0, 16'h0000, 0};
    vecs[11] = '{0, 0, 1, 16'h9999, 1, 8'd2, 3, 0, 1, 2, 1, 16'h00C3, 0};

    // Reset state
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 16'h0, 0, 8'd0);
    applyStimulus(0, 0, 0, 16'h0, 0, 8'd0);
    check("rst_cnt", 32'(a_word_cnt), 32'd0);
    check("rst_loaded", 32'(a_loaded), 32'd0);
    check("rst_ready", 32'(a_wr_ready), 32'd0);
    check("rst_valid", 32'(a_rd_valid), 32'd0);
    check("rst_data", 32'(a_rd_data), 32'd0);
    rst_n = 1'b1;

    // Short load, read-back and out-of-range read
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].ls, vecs[i].le, vecs[i].wv, vecs[i].wd, vecs[i].re, vecs[i].ra);
      checkOutput(i);
    end

    // Fill the whole memory with valid held high; the 257th word must be dropped
    applyStimulus(1, 0, 0, 16'h0, 0, 8'd0);
    for (int i = 0; i < 260; i++) applyStimulus(0, 0, 1, 16'h1000 + 16'(i), 0, 8'd0);
    check("full_cnt", 32'(a_word_cnt), 32'd256);
    check("full_max", 32'(a_max_addr), 32'd255);
    check("full_loaded", 32'(a_loaded), 32'd1);
    check("full_ready", 32'(a_wr_ready), 32'd0);
    applyStimulus(0, 0, 0, 16'h0, 1, 8'd0);
    check("full_addr0", 32'(a_rd_data), 32'h1000);
    applyStimulus(0, 0, 0, 16'h0, 1, 8'd255);
    check("full_addr255", 32'(a_rd_data), 32'h10FF);

    // Reload over a full memory: write and read addr 0 together
    applyStimulus(1, 0, 0, 16'h0, 0, 8'd0);
    applyStimulus(0, 0, 1, 16'h5555, 1, 8'd0);
    check("coll_oob", 32'(a_rd_oob), 32'd1);
    check("coll_data", 32'(a_rd_data), 32'h0);
    check("coll_valid", 32'(a_rd_valid), 32'd1);
    applyStimulus(0, 0, 0, 16'h0, 1, 8'd0);
    check("coll_reread", 32'(a_rd_data), 32'h5555);
    check("coll_reread_oob", 32'(a_rd_oob), 32'd0);

    // Reset mid-load with a latency-2 read in flight
    applyStimulus(0, 0, 1, 16'h7777, 0, 8'd0);
    applyStimulus(0, 0, 0, 16'h0, 1, 8'd1);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 16'h0, 0, 8'd0);
    check("flush_b_valid", 32'(b_rd_valid), 32'd0);
    check("flush_cnt", 32'(b_word_cnt), 32'd0);
    check("flush_loaded", 32'(b_loaded), 32'd0);
    check("flush_ready", 32'(b_wr_ready), 32'd0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 16'h0, 0, 8'd0);
    check("flush_b_valid2", 32'(b_rd_valid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      load_start = ($urandom_range(0, 59) == 0);
      load_end   = ($urandom_range(0, 49) == 0);
      wr_valid   = ($urandom_range(0, 3) != 0);
      wr_data    = 16'($urandom);
      rd_en      = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1)
        rd_addr = 8'($urandom_range(0, 255));
      else
        rd_addr = 8'(m_cnt + $urandom_range(0, 4) - 2);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
